// File: rtl/frame_swap_ctrl.sv
// frame_swap_ctrl: VBLANK-synchronised double-buffer page flip; ports: clk, rst (sync, active-low), VBLANK/CLRVBLNK/DISPADDR/DISPON to the display engine, swap_req/swap_ack/busy/back_addr/frame_cnt to the renderer, timeout_err/err_clr for stalled VBLANK waits
module frame_swap_ctrl #(
  parameter logic [29:0] BUF0_ADDR = 30'h10426240,
  parameter logic [29:0] BUF1_ADDR = 30'h10440000,
  parameter int FCNT_W = 16,
  parameter int TIMEOUT = 2000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              VBLANK,
  output logic              CLRVBLNK,
  output logic [29:0]       DISPADDR,
  output logic              DISPON,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              busy,
  output logic [29:0]       back_addr,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              timeout_err,
  input  logic              err_clr
);
  typedef enum logic [2:0] {INIT, WAIT_FIRST, IDLE, ARM, WAIT_VBL} state_t;
  localparam int CW = $clog2(TIMEOUT);
  state_t state;
  logic front_sel;
  logic [CW-1:0] wcnt;
  logic waiting, to_hit;
  assign busy = state != IDLE;
  assign back_addr = front_sel ? BUF0_ADDR : BUF1_ADDR;
  assign waiting = (state == WAIT_FIRST || state == WAIT_VBL) && !VBLANK;
  assign to_hit = wcnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      CLRVBLNK <= 1'b1;
      DISPADDR <= '0;
      DISPON <= 1'b0;
      front_sel <= 1'b0;
      swap_ack <= 1'b0;
      frame_cnt <= '0;
      timeout_err <= 1'b0;
      wcnt <= '0;
    end else begin
      swap_ack <= 1'b0;
      CLRVBLNK <= 1'b0;
      timeout_err <= (waiting && to_hit) ? 1'b1 : err_clr ? 1'b0 : timeout_err;
      if (waiting && !to_hit) wcnt <= wcnt + CW'(1);
      case (state)
        INIT: begin
          wcnt <= '0;
          state <= WAIT_FIRST;
        end
        WAIT_FIRST: if (VBLANK) begin
          DISPADDR <= BUF0_ADDR;
          DISPON <= 1'b1;
          CLRVBLNK <= 1'b1;
          state <= IDLE;
        end
        IDLE: if (swap_req) begin
          CLRVBLNK <= 1'b1;
          state <= ARM;
        end
        ARM: begin
          wcnt <= '0;
          state <= WAIT_VBL;
        end
        WAIT_VBL: if (VBLANK) begin
          front_sel <= ~front_sel;
          DISPADDR <= front_sel ? BUF0_ADDR : BUF1_ADDR;
          CLRVBLNK <= 1'b1;
          frame_cnt <= frame_cnt + FCNT_W'(1);
          swap_ack <= 1'b1;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule
